uart_baud_nco: RTL

//   Runtime-selectable UART baud tick generator for the TX and RX datapaths of the UART.
//   It replaces the fixed-divisor, TX-only generator with two phase-accumulator (NCO) channels.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_nco_chan.sv | 74 +++++++
 rtl/uart_baud_nco.sv | 80 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud tick generator: baud table, channel FSM states
// and an elaboration-time ceiling log2.
package uart_pkg;

  localparam int BAUD_SEL_W = 3;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_t;

  function automatic int unsigned baud_rate(input logic [BAUD_SEL_W-1:0] sel);
    case (sel)
      3'd0:    return 32'd9600;
      3'd1:    return 32'd19200;
      3'd2:    return 32'd38400;
      3'd3:    return 32'd57600;
      3'd4:    return 32'd115200;
      3'd5:    return 32'd230400;
      3'd6:    return 32'd460800;
      default: return 32'd921600;
    endcase
  endfunction

  function automatic int clog2(input longint unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_nco_chan.sv
// One NCO tick channel: IDLE/RUN control, latched baud select, phase accumulator and
// a registered one-cycle strobe that fires each time the accumulator wraps past the clock rate.
module uart_nco_chan
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCE = 125_000_000,
  parameter int unsigned MULT          = 1,
  parameter bit          PRELOAD_FULL  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic [BAUD_SEL_W-1:0] baud_sel,
  input  logic                  start,
  input  logic                  done,
  output logic                  strobe,
  output logic                  busy
);

  localparam int ACC_W = clog2(CLK_FREQUENCE) + 1;
  localparam logic [ACC_W-1:0] MOD = ACC_W'(CLK_FREQUENCE);

  chan_state_t           state_q, state_d;
  logic [BAUD_SEL_W-1:0] sel_q;
  logic [ACC_W-1:0]      acc_q;
  logic [ACC_W-1:0]      inc_run;
  logic [ACC_W-1:0]      sum;
  logic [ACC_W-1:0]      preload;
  logic                  start_edge;

  function automatic logic [ACC_W-1:0] inc_of(input logic [BAUD_SEL_W-1:0] s);
    return ACC_W'(baud_rate(s) * MULT);
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_IDLE: if (start) state_d = CH_RUN;
      CH_RUN:  if (done)  state_d = CH_IDLE;
    endcase
  end

  assign start_edge = (state_q == CH_IDLE) && start;
  assign inc_run    = inc_of(sel_q);
  assign sum        = acc_q + inc_run;
  // A full preload makes the very first RUN cycle wrap, so the TX strobe leads the bit.
  assign preload    = PRELOAD_FULL ? (MOD - inc_of(baud_sel)) : '0;
  assign busy       = (state_q == CH_RUN);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= CH_IDLE;
      sel_q   <= '0;
      acc_q   <= '0;
      strobe  <= 1'b0;
    end else begin
      state_q <= state_d;
      strobe  <= 1'b0;
      if (start_edge) begin
        sel_q <= baud_sel;
        acc_q <= preload;
      end else if ((state_q == CH_RUN) && !done) begin
        if (sum >= MOD) begin
          acc_q  <= sum - MOD;
          strobe <= 1'b1;
        end else begin
          acc_q <= sum;
        end
      end else begin
        acc_q <= '0;
      end
    end
  end

endmodule

// File: rtl/uart_baud_nco.sv
// UART baud tick generator: TX 1x bit strobe and RX oversample strobe with a mid-bit
// strobe, each driven by its own NCO channel.
module uart_baud_nco
  import uart_pkg::*;
#(
  parameter int unsigned           CLK_FREQUENCE = 125_000_000,
  parameter int unsigned           OVERSAMPLE    = 16,
  parameter logic [BAUD_SEL_W-1:0] DEFAULT_SEL   = 3'd0
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic [BAUD_SEL_W-1:0] baud_sel,
  input  logic                  tx_start,
  input  logic                  tx_done,
  input  logic                  rx_start,
  input  logic                  rx_done,
  output logic                  tx_bps_clk,
  output logic                  rx_os_clk,
  output logic                  rx_mid_clk,
  output logic                  tx_busy,
  output logic                  rx_busy
);

  localparam int OS_W = clog2(OVERSAMPLE);

  if (64'(921600) * 64'(OVERSAMPLE) * 64'd2 > 64'(CLK_FREQUENCE)) begin : g_rate_chk
    $error("uart_baud_nco: clock too slow for 921600 baud at OVERSAMPLE=%0d", OVERSAMPLE);
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE > 16) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
    $error("uart_baud_nco: OVERSAMPLE must be even and within 4..16");
  end

  logic [BAUD_SEL_W-1:0] eff_sel;
  logic [OS_W-1:0]       os_cnt;

  // An input held at its reset value selects the build-time default rate.
  assign eff_sel = (baud_sel == '0) ? DEFAULT_SEL : baud_sel;

  uart_nco_chan #(
    .CLK_FREQUENCE (CLK_FREQUENCE),
    .MULT          (1),
    .PRELOAD_FULL  (1'b1)
  ) u_tx_chan (
    .clk      (clk),
    .reset_p  (reset_p),
    .baud_sel (eff_sel),
    .start    (tx_start),
    .done     (tx_done),
    .strobe   (tx_bps_clk),
    .busy     (tx_busy)
  );

  uart_nco_chan #(
    .CLK_FREQUENCE (CLK_FREQUENCE),
    .MULT          (OVERSAMPLE),
    .PRELOAD_FULL  (1'b0)
  ) u_rx_chan (
    .clk      (clk),
    .reset_p  (reset_p),
    .baud_sel (eff_sel),
    .start    (rx_start),
    .done     (rx_done),
    .strobe   (rx_os_clk),
    .busy     (rx_busy)
  );

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      os_cnt <= '0;
    end else if (rx_start && !rx_busy) begin
      os_cnt <= '0;
    end else if (rx_os_clk) begin
      os_cnt <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
    end
  end

  // os_cnt still holds the pre-increment count while its strobe is visible.
  assign rx_mid_clk = rx_os_clk && (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));

endmodule
